// File: rtl/lidar_link_pkg.sv
// Shared LiDAR-over-HDMI link definitions: point payload, pixel lane layout and quad phases.
// The receive-side parser imports the same package so both ends agree on byte placement.
package lidar_link_pkg;

  localparam int unsigned PIX_PER_PT = 4;
  localparam int unsigned PHASE_W    = $clog2(PIX_PER_PT);
  localparam int unsigned COORD_W    = 16;
  localparam int unsigned INTENS_W   = 8;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned PIX_W      = 3 * LANE_W;
  localparam int unsigned G_HI       = 15;
  localparam int unsigned G_LO       = 8;
  localparam int unsigned B_HI       = 7;
  localparam int unsigned B_LO       = 0;

  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] z;
    logic [INTENS_W-1:0]       intens;
    logic                      flag;
  } point_t;

  typedef enum logic [PHASE_W-1:0] {
    PH_XZ_HI     = 2'd0,
    PH_XZ_LO     = 2'd1,
    PH_Y_HI_INT  = 2'd2,
    PH_Y_LO_FLAG = 2'd3
  } phase_e;

  // {G,B} lanes carried by one pixel of a quad.
  function automatic logic [G_HI:B_LO] pixel_lanes(point_t p, phase_e ph);
    logic [G_HI:B_LO] lanes;
    lanes = '0;
    case (ph)
      PH_XZ_HI:     lanes = {p.x[15:8], p.z[15:8]};
      PH_XZ_LO:     lanes = {p.x[7:0],  p.z[7:0]};
      PH_Y_HI_INT:  lanes = {p.y[15:8], p.intens};
      PH_Y_LO_FLAG: lanes = {p.y[7:0],  7'b0, p.flag};
      default:      lanes = '0;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/lidar_hdmi_packer_if.sv
// Point producer -> packer handshake bus (valid/ready with one point per transfer).
interface lidar_hdmi_packer_if;
  import lidar_link_pkg::*;

  logic                      pt_valid;
  logic                      pt_ready;
  logic signed [COORD_W-1:0] pt_x;
  logic signed [COORD_W-1:0] pt_y;
  logic signed [COORD_W-1:0] pt_z;
  logic [INTENS_W-1:0]       pt_intens;
  logic                      pt_flag;

  modport master (output pt_valid, pt_x, pt_y, pt_z, pt_intens, pt_flag, input pt_ready);
  modport slave  (input pt_valid, pt_x, pt_y, pt_z, pt_intens, pt_flag, output pt_ready);
endinterface

// File: rtl/lidar_hdmi_packer.sv
// Packs LiDAR points into 4-pixel RGB quads aligned to the external active-video strobe.
// Idle slots are filled with all-zero padding quads so the receiver never sees partial points.
module lidar_hdmi_packer
  import lidar_link_pkg::*;
#(
  parameter logic [LANE_W-1:0] R_FILL = 8'h00,
  parameter int unsigned       CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  de_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  lidar_hdmi_packer_if.slave    pt_if,
  output logic [PIX_W-1:0]      pixel_out,
  output logic                  de_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic [CNT_W-1:0]      pts_sent,
  output logic [CNT_W-1:0]      pad_sent
);

  phase_e           phase, phase_nxt;
  logic             hold_full, hold_full_nxt;
  point_t           hold_q, hold_nxt;
  point_t           tx_q, tx_nxt;
  logic             tx_real, tx_real_nxt;
  logic [PIX_W-1:0] pixel_nxt;
  logic [CNT_W-1:0] pts_nxt, pad_nxt;
  point_t           in_pt;
  point_t           lane_src;
  logic             quad_start;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= PH_XZ_HI;
      hold_full <= 1'b0;
      hold_q    <= '0;
      tx_q      <= '0;
      tx_real   <= 1'b0;
      pixel_out <= '0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      pts_sent  <= '0;
      pad_sent  <= '0;
    end else begin
      phase     <= phase_nxt;
      hold_full <= hold_full_nxt;
      hold_q    <= hold_nxt;
      tx_q      <= tx_nxt;
      tx_real   <= tx_real_nxt;
      pixel_out <= pixel_nxt;
      de_out    <= de_in;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      pts_sent  <= pts_nxt;
      pad_sent  <= pad_nxt;
    end
  end

  always_comb begin
    phase_nxt     = phase;
    hold_full_nxt = hold_full;
    hold_nxt      = hold_q;
    tx_nxt        = tx_q;
    tx_real_nxt   = tx_real;
    pts_nxt       = pts_sent;
    pad_nxt       = pad_sent;
    pixel_nxt     = '0;

    in_pt = {pt_if.pt_x, pt_if.pt_y, pt_if.pt_z, pt_if.pt_intens, pt_if.pt_flag};
    quad_start     = de_in && (phase == PH_XZ_HI);
    pt_if.pt_ready = !hold_full || quad_start;
    accept         = pt_if.pt_valid && pt_if.pt_ready;

    if (de_in) begin
      phase_nxt = phase_e'(PHASE_W'(phase) + PHASE_W'(1));
    end

    // A quad launches whatever sits in hold; an empty hold becomes a padding quad.
    if (quad_start) begin
      tx_nxt        = hold_full ? hold_q : '0;
      tx_real_nxt   = hold_full;
      hold_full_nxt = 1'b0;
    end

    // Refill after the launch so a same-cycle accept keeps the new point in hold.
    if (accept) begin
      hold_nxt      = in_pt;
      hold_full_nxt = 1'b1;
    end

    lane_src = (phase == PH_XZ_HI) ? tx_nxt : tx_q;
    if (de_in) begin
      pixel_nxt = {R_FILL, pixel_lanes(lane_src, phase)};
    end

    if (de_in && (phase == PH_Y_LO_FLAG)) begin
      if (tx_real) begin
        if (pts_sent != '1) pts_nxt = pts_sent + CNT_W'(1);
      end else begin
        if (pad_sent != '1) pad_nxt = pad_sent + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lidar_hdmi_packer.sv
// Directed vector table plus a random loopback through a bench-side receive parser.
module tb_lidar_hdmi_packer;
  import lidar_link_pkg::*;

  localparam int unsigned CNT_W = 32;
  localparam int NPTS = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              de_in, hsync_in, vsync_in;
  logic [PIX_W-1:0]  pixel_out;
  logic              de_out, hsync_out, vsync_out;
  logic [CNT_W-1:0]  pts_sent, pad_sent;

  int checks = 0;
  int errors = 0;

  lidar_hdmi_packer_if pt_if ();

  lidar_hdmi_packer #(.R_FILL(8'h00), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pt_if(pt_if), .pixel_out(pixel_out), .de_out(de_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .pts_sent(pts_sent), .pad_sent(pad_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, de, v, hs, vs;
    point_t      p;
    logic [23:0] pix;
    bit          rdy;
    int          pts, pad;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(bit r, bit de, bit v, point_t p, logic [23:0] pix, bit rdy,
                     int pts, int pad, bit hs = 1'b0, bit vs = 1'b0);
    vec_t t;
    t.rst = r; t.de = de; t.v = v; t.p = p; t.pix = pix; t.rdy = rdy;
    t.pts = pts; t.pad = pad; t.hs = hs; t.vs = vs;
    tbl.push_back(t);
  endtask

  task automatic apply(bit r, bit de, bit v, point_t p, bit hs, bit vs);
    rst = r; de_in = de; hsync_in = hs; vsync_in = vs;
    pt_if.pt_valid = v;
    pt_if.pt_x = p.x; pt_if.pt_y = p.y; pt_if.pt_z = p.z;
    pt_if.pt_intens = p.intens; pt_if.pt_flag = p.flag;
  endtask

  function automatic point_t rand_pt();
    point_t r;
    r.x = 16'($urandom); r.y = 16'($urandom); r.z = 16'($urandom);
    r.intens = 8'($urandom); r.flag = 1'b1;
    return r;
  endfunction

  initial begin
    point_t p, a, b, c, z, cur, exp_pt, rx_pt;
    point_t exp_q[$];
    logic [23:0] rx[4];
    bit rdy_s, have;
    int rx_n, got, sent, cyc, rx_pad;

    p = '{x:16'h1234, y:16'hABCD, z:16'h8001, intens:8'h5A, flag:1'b1};
    a = '{x:16'h1122, y:16'h3344, z:16'h5566, intens:8'h77, flag:1'b1};
    b = '{x:16'h8899, y:16'hAABB, z:16'hCCDD, intens:8'hEE, flag:1'b0};
    c = '{x:16'hFEDC, y:16'hBA98, z:16'h7654, intens:8'h32, flag:1'b1};
    z = '0;

    apply(1, 0, 0, z, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Single point loaded during blanking, then one full quad.
    add(1, 0, 0, z, 24'h0, 1, 0, 0);
    add(0, 0, 1, p, 24'h0, 1, 0, 0);
    add(0, 1, 0, z, 24'h001280, 1, 0, 0);
    add(0, 1, 0, z, 24'h003401, 1, 0, 0);
    add(0, 1, 0, z, 24'h00AB5A, 1, 0, 0);
    add(0, 1, 0, z, 24'h00CD01, 1, 1, 0);
    // Starved producer: two padding quads.
    add(1, 0, 0, z, 24'h0, 1, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, z, 24'h0, 1, 0, (i >= 7) ? 2 : (i >= 3) ? 1 : 0);
    // Blanking gap after p1; quad resumes at p2 with syncs passed through.
    add(1, 0, 0, z, 24'h0, 1, 0, 0);
    add(0, 0, 1, p, 24'h0, 1, 0, 0);
    add(0, 1, 0, z, 24'h001280, 1, 0, 0);
    add(0, 1, 0, z, 24'h003401, 1, 0, 0);
    add(0, 0, 0, z, 24'h0, 1, 0, 0, 1, 0);
    add(0, 0, 0, z, 24'h0, 1, 0, 0, 1, 0);
    add(0, 0, 0, z, 24'h0, 1, 0, 0, 1, 1);
    add(0, 0, 0, z, 24'h0, 1, 0, 0, 0, 1);
    add(0, 0, 0, z, 24'h0, 1, 0, 0);
    add(0, 1, 0, z, 24'h00AB5A, 1, 0, 0);
    add(0, 1, 0, z, 24'h00CD01, 1, 1, 0);
    // Back-to-back points with valid held high.
    add(1, 0, 0, z, 24'h0, 1, 0, 0);
    add(0, 1, 1, a, 24'h0, 1, 0, 0);
    add(0, 1, 1, b, 24'h0, 0, 0, 0);
    add(0, 1, 1, b, 24'h0, 0, 0, 0);
    add(0, 1, 1, b, 24'h0, 0, 0, 1);
    add(0, 1, 1, b, 24'h001155, 1, 0, 1);
    add(0, 1, 1, c, 24'h002266, 0, 0, 1);
    add(0, 1, 1, c, 24'h003377, 0, 0, 1);
    add(0, 1, 1, c, 24'h004401, 0, 1, 1);
    add(0, 1, 1, c, 24'h0088CC, 1, 1, 1);
    add(0, 1, 0, z, 24'h0099DD, 0, 1, 1);
    add(0, 1, 0, z, 24'h00AAEE, 0, 1, 1);
    add(0, 1, 0, z, 24'h00BB00, 0, 2, 1);
    add(0, 1, 0, z, 24'h00FE76, 1, 2, 1);
    add(0, 1, 0, z, 24'h00DC54, 1, 2, 1);
    add(0, 1, 0, z, 24'h00BA32, 1, 2, 1);
    add(0, 1, 0, z, 24'h009801, 1, 3, 1);
    // Reset at phase 2 aborts the quad; next quad starts at p0.
    add(1, 0, 0, z, 24'h0, 1, 0, 0);
    add(0, 0, 1, p, 24'h0, 1, 0, 0);
    add(0, 1, 0, z, 24'h001280, 1, 0, 0);
    add(0, 1, 0, z, 24'h003401, 1, 0, 0);
    add(1, 1, 0, z, 24'h0, 1, 0, 0, 1, 1);
    add(0, 0, 1, p, 24'h0, 1, 0, 0);
    add(0, 1, 0, z, 24'h001280, 1, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].de, tbl[i].v, tbl[i].p, tbl[i].hs, tbl[i].vs);
      #1 rdy_s = pt_if.pt_ready;
      @(posedge clk);
      #1;
      chk($sformatf("r%0d pixel", i), 64'(pixel_out), 64'(tbl[i].pix));
      chk($sformatf("r%0d de_out", i), 64'(de_out), 64'(tbl[i].de & !tbl[i].rst));
      chk($sformatf("r%0d hsync", i), 64'(hsync_out), 64'(tbl[i].hs & !tbl[i].rst));
      chk($sformatf("r%0d vsync", i), 64'(vsync_out), 64'(tbl[i].vs & !tbl[i].rst));
      chk($sformatf("r%0d ready", i), 64'(rdy_s), 64'(tbl[i].rdy));
      chk($sformatf("r%0d pts", i), 64'(pts_sent), 64'(tbl[i].pts));
      chk($sformatf("r%0d pad", i), 64'(pad_sent), 64'(tbl[i].pad));
    end

    // Random loopback with de gaps and valid bubbles; parser resyncs via shared reset.
    apply(1, 0, 0, z, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_n = 0; got = 0; sent = 0; cyc = 0; rx_pad = 0; have = 1'b0; cur = z;
    while (got < NPTS && cyc < 20000) begin
      if (!have && sent < NPTS) begin
        cur = rand_pt();
        have = 1'b1;
      end
      apply(0, ($urandom_range(0, 3) != 0), have && ($urandom_range(0, 3) != 0), cur, 0, 0);
      #1;
      if (pt_if.pt_valid && pt_if.pt_ready) begin
        exp_q.push_back(cur);
        have = 1'b0;
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (de_out) begin
        rx[rx_n] = pixel_out;
        rx_n++;
        if (rx_n == PIX_PER_PT) begin
          rx_n = 0;
          rx_pt.x = {rx[0][15:8], rx[1][15:8]};
          rx_pt.z = {rx[0][7:0], rx[1][7:0]};
          rx_pt.y = {rx[2][15:8], rx[3][15:8]};
          rx_pt.intens = rx[2][7:0];
          rx_pt.flag = rx[3][0];
          if (!rx_pt.flag) begin
            rx_pad++;
          end else if (exp_q.size() == 0) begin
            chk("loop unexpected point", 64'(rx_pt), 64'(0));
          end else begin
            exp_pt = exp_q.pop_front();
            chk($sformatf("loop pt %0d", got), 64'(rx_pt), 64'(exp_pt));
            got++;
          end
        end
      end
    end
    chk("loop received", 64'(got), 64'(NPTS));
    chk("loop pts_sent", 64'(pts_sent), 64'(NPTS));
    chk("loop pad_sent", 64'(pad_sent), 64'(rx_pad));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
